// File: rtl/cnn_layer_accel_quad_pkt_tx_if.sv
// Bundle of the configuration, weight/pixel stream, credit and quad-facing packet signals.
// master = upstream source and quad sink, slave = packet transmitter.
interface cnn_layer_accel_quad_pkt_tx_if #(
  parameter int unsigned C_NUM_PFB      = 8,
  parameter int unsigned C_PIXEL_WIDTH  = 18,
  parameter int unsigned C_PACKET_WIDTH = 144
);
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [15:0]                          cfg_num_input_cols;
  logic [15:0]                          cfg_num_input_rows;
  logic [15:0]                          cfg_input_depth;
  logic [15:0]                          cfg_num_kernels;
  logic [15:0]                          cfg_kernel_size;
  logic [31:0]                          cfg_num_weight_pkts;
  logic [31:0]                          cfg_num_pixel_pkts;
  logic                                 wt_valid;
  logic                                 wt_ready;
  logic [C_PACKET_WIDTH-1:0]            wt_data;
  logic                                 pix_valid;
  logic                                 pix_ready;
  logic [C_NUM_PFB*C_PIXEL_WIDTH-1:0]   pix_data;
  logic                                 credit_return;
  logic                                 config_wren;
  logic                                 weight_wren;
  logic                                 pixel_datain_valid;
  logic [C_PACKET_WIDTH-1:0]            datain;
  logic                                 busy;
  logic                                 done;
  logic                                 credit_err;

  modport master (
    output cfg_valid, cfg_num_input_cols, cfg_num_input_rows, cfg_input_depth, cfg_num_kernels,
           cfg_kernel_size, cfg_num_weight_pkts, cfg_num_pixel_pkts, wt_valid, wt_data,
           pix_valid, pix_data, credit_return,
    input  cfg_ready, wt_ready, pix_ready, config_wren, weight_wren, pixel_datain_valid, datain,
           busy, done, credit_err
  );

  modport slave (
    input  cfg_valid, cfg_num_input_cols, cfg_num_input_rows, cfg_input_depth, cfg_num_kernels,
           cfg_kernel_size, cfg_num_weight_pkts, cfg_num_pixel_pkts, wt_valid, wt_data,
           pix_valid, pix_data, credit_return,
    output cfg_ready, wt_ready, pix_ready, config_wren, weight_wren, pixel_datain_valid, datain,
           busy, done, credit_err
  );
endinterface

// File: rtl/cnn_layer_accel_quad_pkt_tx.sv
// Quad input packet transmitter: config, weights, start, then credit-gated pixel packets.
// All quad-facing strobes and datain are registered.
module cnn_layer_accel_quad_pkt_tx #(
  parameter int unsigned C_NUM_PFB      = 8,
  parameter int unsigned C_PIXEL_WIDTH  = 18,
  parameter int unsigned C_PACKET_WIDTH = 144,
  parameter int unsigned C_PFB_DEPTH    = 512
) (
  input logic                           network_clk,
  input logic                           network_rst,
  cnn_layer_accel_quad_pkt_tx_if.slave  bus
);
  localparam int unsigned PixW    = C_NUM_PFB * C_PIXEL_WIDTH;
  localparam int unsigned CreditW = $clog2(C_PFB_DEPTH) + 1;
  localparam logic [CreditW-1:0] CreditMax = CreditW'(C_PFB_DEPTH);

  typedef enum logic [2:0] {StIdle, StSendCfg, StWeights, StStart, StPixels, StDone} state_e;

  state_e                    state_q, state_d;
  logic [79:0]               cfg_word_q, cfg_word_d;
  logic [31:0]               wt_total_q, wt_total_d, pix_total_q, pix_total_d;
  logic [31:0]               wt_cnt_q, wt_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [CreditW-1:0]        credit_q, credit_d;
  logic                      credit_err_q, credit_err_d;
  logic                      config_wren_q, config_wren_d, weight_wren_q, weight_wren_d;
  logic                      pix_valid_q, pix_valid_d, done_q, done_d;
  logic [C_PACKET_WIDTH-1:0] datain_q, datain_d;
  logic                      cfg_fire, wt_fire, pix_fire;

  assign bus.cfg_ready          = (state_q == StIdle);
  assign bus.busy               = (state_q != StIdle);
  assign bus.wt_ready           = (state_q == StWeights);
  assign bus.pix_ready          = (state_q == StPixels) && (credit_q != '0);
  assign bus.config_wren        = config_wren_q;
  assign bus.weight_wren        = weight_wren_q;
  assign bus.pixel_datain_valid = pix_valid_q;
  assign bus.datain             = datain_q;
  assign bus.done               = done_q;
  assign bus.credit_err         = credit_err_q;

  assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
  assign wt_fire  = bus.wt_valid & bus.wt_ready;
  assign pix_fire = bus.pix_valid & bus.pix_ready;

  always_comb begin
    state_d       = state_q;
    cfg_word_d    = cfg_word_q;
    wt_total_d    = wt_total_q;
    pix_total_d   = pix_total_q;
    wt_cnt_d      = wt_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    datain_d      = datain_q;
    config_wren_d = 1'b0;
    weight_wren_d = 1'b0;
    pix_valid_d   = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          cfg_word_d  = {bus.cfg_kernel_size, bus.cfg_num_kernels, bus.cfg_input_depth,
                         bus.cfg_num_input_rows, bus.cfg_num_input_cols};
          wt_total_d  = bus.cfg_num_weight_pkts;
          pix_total_d = bus.cfg_num_pixel_pkts;
          wt_cnt_d    = '0;
          pix_cnt_d   = '0;
          state_d     = StSendCfg;
        end
      end
      StSendCfg: begin
        config_wren_d  = 1'b1;
        datain_d       = '0;
        datain_d[79:0] = cfg_word_q;
        state_d        = (wt_total_q != '0) ? StWeights : StStart;
      end
      StWeights: begin
        if (wt_fire) begin
          weight_wren_d = 1'b1;
          datain_d      = bus.wt_data;
          wt_cnt_d      = wt_cnt_q + 32'd1;
          if (wt_cnt_d == wt_total_q) state_d = StStart;
        end
      end
      StStart: begin
        config_wren_d  = 1'b1;
        datain_d       = '0;
        datain_d[79:0] = cfg_word_q;
        datain_d[80]   = 1'b1;
        state_d        = (pix_total_q != '0) ? StPixels : StDone;
      end
      StPixels: begin
        if (pix_fire) begin
          pix_valid_d          = 1'b1;
          datain_d             = '0;
          datain_d[PixW-1:0]   = bus.pix_data;
          pix_cnt_d            = pix_cnt_q + 32'd1;
          if (pix_cnt_d == pix_total_q) state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Credit mirrors free PFB slots; a return at full credit is a protocol error, not a wrap.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (pix_fire && !bus.credit_return) begin
      credit_d = credit_q - 1'b1;
    end else if (!pix_fire && bus.credit_return) begin
      if (credit_q == CreditMax) credit_err_d = 1'b1;
      else                       credit_d     = credit_q + 1'b1;
    end
  end

  always_ff @(posedge network_clk or posedge network_rst) begin
    if (network_rst) begin
      state_q       <= StIdle;
      cfg_word_q    <= '0;
      wt_total_q    <= '0;
      pix_total_q   <= '0;
      wt_cnt_q      <= '0;
      pix_cnt_q     <= '0;
      credit_q      <= CreditMax;
      credit_err_q  <= 1'b0;
      config_wren_q <= 1'b0;
      weight_wren_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      datain_q      <= '0;
    end else begin
      state_q       <= state_d;
      cfg_word_q    <= cfg_word_d;
      wt_total_q    <= wt_total_d;
      pix_total_q   <= pix_total_d;
      wt_cnt_q      <= wt_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      credit_q      <= credit_d;
      credit_err_q  <= credit_err_d;
      config_wren_q <= config_wren_d;
      weight_wren_q <= weight_wren_d;
      pix_valid_q   <= pix_valid_d;
      done_q        <= done_d;
      datain_q      <= datain_d;
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_quad_pkt_tx.sv
// Directed bench for the quad packet transmitter: per-cycle strobe/ready tables per layer,
// credit flow control, credit error and reset abort.
module tb_cnn_layer_accel_quad_pkt_tx;
  localparam int unsigned NPFB  = 8;
  localparam int unsigned PW    = 18;
  localparam int unsigned PKT   = 160;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PIXW  = NPFB * PW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_quad_pkt_tx_if #(
    .C_NUM_PFB      (NPFB),
    .C_PIXEL_WIDTH  (PW),
    .C_PACKET_WIDTH (PKT)
  ) bus ();

  cnn_layer_accel_quad_pkt_tx #(
    .C_NUM_PFB      (NPFB),
    .C_PIXEL_WIDTH  (PW),
    .C_PACKET_WIDTH (PKT),
    .C_PFB_DEPTH    (DEPTH)
  ) dut (
    .network_clk (clk),
    .network_rst (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle tables, index = cycles after the cfg handshake edge.
  // exp_tab = {config_wren, weight_wren, pixel_datain_valid, done}.
  logic [3:0]     exp_tab [16];
  logic           wr_tab [16];
  logic           pr_tab [16];
  logic           pv_tab [16];
  logic           cr_tab [16];
  logic           cv_tab [16];
  int             cred_tab [16];
  logic [79:0]    exp_cfg;
  logic [PKT-1:0] last_data;

  function automatic logic [PKT-1:0] wpat(input int n);
    logic [7:0] b;
    b = 8'(8'hA0 + n);
    return {20{b}};
  endfunction

  function automatic logic [PIXW-1:0] ppat(input int n);
    logic [7:0] b;
    b = 8'(8'h30 + n);
    return {18{b}};
  endfunction

  task automatic check_eq(input string tag, input logic [PKT-1:0] obs, input logic [PKT-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_tabs();
    for (int i = 0; i < 16; i++) begin
      exp_tab[i]  = 4'h0;
      wr_tab[i]   = 1'b0;
      pr_tab[i]   = 1'b0;
      pv_tab[i]   = 1'b1;
      cr_tab[i]   = 1'b0;
      cv_tab[i]   = 1'b0;
      cred_tab[i] = -1;
    end
  endtask

  task automatic offer_cfg(input logic [15:0] cols, input logic [15:0] rows,
                           input logic [15:0] depth, input logic [15:0] kern,
                           input logic [15:0] ks, input logic [31:0] nw, input logic [31:0] np);
    @(negedge clk);
    bus.cfg_num_input_cols  = cols;
    bus.cfg_num_input_rows  = rows;
    bus.cfg_input_depth     = depth;
    bus.cfg_num_kernels     = kern;
    bus.cfg_kernel_size     = ks;
    bus.cfg_num_weight_pkts = nw;
    bus.cfg_num_pixel_pkts  = np;
    bus.cfg_valid           = 1'b1;
    exp_cfg                 = {ks, kern, depth, rows, cols};
  endtask

  task automatic run_layer(input string name, input int n);
    int             cfg_seen;
    logic [PKT-1:0] pkt;
    cfg_seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) bus.cfg_valid = 1'b0;
      check_eq($sformatf("%s_c%0d_strb", name, c),
               {bus.config_wren, bus.weight_wren, bus.pixel_datain_valid, bus.done}, exp_tab[c]);
      if (exp_tab[c][3]) begin
        pkt        = '0;
        pkt[79:0]  = exp_cfg;
        pkt[80]    = (cfg_seen != 0);
        cfg_seen++;
        last_data  = pkt;
      end else if (exp_tab[c][2]) begin
        last_data  = wpat(c);
      end else if (exp_tab[c][1]) begin
        pkt        = '0;
        pkt[PIXW-1:0] = ppat(c);
        last_data  = pkt;
      end
      check_eq($sformatf("%s_c%0d_data", name, c), bus.datain, last_data);
      check_eq($sformatf("%s_c%0d_rdy", name, c), {bus.wt_ready, bus.pix_ready},
               {wr_tab[c], pr_tab[c]});
      check_eq($sformatf("%s_c%0d_busy", name, c), {bus.busy, bus.cfg_ready},
               exp_tab[c][0] ? 2'b01 : 2'b10);
      if (cred_tab[c] >= 0)
        check_eq($sformatf("%s_c%0d_credit", name, c), dut.credit_q, cred_tab[c]);
      bus.wt_data       = wpat(c + 1);
      bus.pix_data      = ppat(c + 1);
      bus.pix_valid     = pv_tab[c];
      bus.credit_return = cr_tab[c];
      bus.cfg_valid     = cv_tab[c];
      if (cv_tab[c]) bus.cfg_num_input_cols = 16'd99;
    end
  endtask

  task automatic pulse_credit(input int n);
    @(negedge clk);
    bus.credit_return = 1'b1;
    repeat (n) @(negedge clk);
    bus.credit_return = 1'b0;
  endtask

  initial begin
    rst                     = 1'b1;
    bus.cfg_valid           = 1'b0;
    bus.cfg_num_input_cols  = '0;
    bus.cfg_num_input_rows  = '0;
    bus.cfg_input_depth     = '0;
    bus.cfg_num_kernels     = '0;
    bus.cfg_kernel_size     = '0;
    bus.cfg_num_weight_pkts = '0;
    bus.cfg_num_pixel_pkts  = '0;
    bus.wt_valid            = 1'b1;
    bus.wt_data             = '0;
    bus.pix_valid           = 1'b1;
    bus.pix_data            = '0;
    bus.credit_return       = 1'b0;
    last_data               = '0;

    // Reset state, with stream valids already high.
    repeat (2) @(negedge clk);
    check_eq("rst_strb", {bus.config_wren, bus.weight_wren, bus.pixel_datain_valid, bus.done},
             4'h0);
    check_eq("rst_data", bus.datain, '0);
    check_eq("rst_rdy", {bus.cfg_ready, bus.wt_ready, bus.pix_ready, bus.busy}, 4'b1000);
    check_eq("rst_credit", dut.credit_q, DEPTH);
    check_eq("rst_err", bus.credit_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_strb", {bus.config_wren, bus.weight_wren, bus.pixel_datain_valid, bus.done},
             4'h0);
    bus.wt_valid  = 1'b0;
    bus.pix_valid = 1'b0;

    // Full layer: 2 weights, 4 pixels, valids held high.
    init_tabs();
    exp_tab[1] = 4'h8; exp_tab[2] = 4'h4; exp_tab[3] = 4'h4; exp_tab[4] = 4'h8;
    for (int i = 5; i <= 8; i++) exp_tab[i] = 4'h2;
    exp_tab[9] = 4'h1;
    wr_tab[1] = 1'b1; wr_tab[2] = 1'b1;
    for (int i = 4; i <= 7; i++) pr_tab[i] = 1'b1;
    bus.wt_valid  = 1'b1;
    bus.pix_valid = 1'b1;
    bus.wt_data   = wpat(0);
    offer_cfg(16'd8, 16'd8, 16'd3, 16'd4, 16'd3, 32'd2, 32'd4);
    run_layer("full", 10);
    bus.wt_valid  = 1'b0;
    bus.pix_valid = 1'b0;
    pulse_credit(4);
    check_eq("full_credit_back", dut.credit_q, DEPTH);

    // Credit exhaustion, return-gated 5th beat, simultaneous accept and return.
    init_tabs();
    exp_tab[1] = 4'h8; exp_tab[2] = 4'h8;
    for (int i = 3; i <= 6; i++) exp_tab[i] = 4'h2;
    exp_tab[10] = 4'h2; exp_tab[12] = 4'h2; exp_tab[13] = 4'h2; exp_tab[14] = 4'h1;
    for (int i = 2; i <= 5; i++) pr_tab[i] = 1'b1;
    pr_tab[9] = 1'b1; pr_tab[11] = 1'b1; pr_tab[12] = 1'b1;
    cr_tab[8] = 1'b1; cr_tab[10] = 1'b1; cr_tab[11] = 1'b1;
    cred_tab[6] = 0; cred_tab[9] = 1; cred_tab[11] = 1; cred_tab[12] = 1; cred_tab[13] = 0;
    bus.pix_valid = 1'b1;
    offer_cfg(16'd16, 16'd16, 16'd1, 16'd1, 16'd1, 32'd0, 32'd7);
    run_layer("credit", 15);
    bus.pix_valid = 1'b0;
    pulse_credit(4);
    check_eq("credit_full", dut.credit_q, DEPTH);
    check_eq("credit_err_clear", bus.credit_err, 1'b0);
    pulse_credit(1);
    check_eq("credit_over", dut.credit_q, DEPTH);
    check_eq("credit_err_set", bus.credit_err, 1'b1);

    // Empty layer: config, start, done on consecutive cycles; readies stay low.
    init_tabs();
    exp_tab[1] = 4'h8; exp_tab[2] = 4'h8; exp_tab[3] = 4'h1;
    bus.wt_valid  = 1'b1;
    bus.pix_valid = 1'b1;
    offer_cfg(16'd4, 16'd4, 16'd2, 16'd2, 16'd1, 32'd0, 32'd0);
    run_layer("empty", 4);
    bus.wt_valid  = 1'b0;
    bus.pix_valid = 1'b0;

    // cfg_valid pulse while stalled in the pixel phase is ignored.
    init_tabs();
    for (int i = 0; i <= 4; i++) pv_tab[i] = 1'b0;
    cv_tab[3] = 1'b1;
    exp_tab[1] = 4'h8; exp_tab[2] = 4'h8; exp_tab[6] = 4'h2; exp_tab[7] = 4'h2;
    exp_tab[8] = 4'h1;
    for (int i = 2; i <= 6; i++) pr_tab[i] = 1'b1;
    offer_cfg(16'd12, 16'd10, 16'd2, 16'd8, 16'd5, 32'd0, 32'd2);
    run_layer("busycfg", 9);
    bus.pix_valid = 1'b0;

    // Next cfg after done is accepted, then reset aborts mid weight phase.
    init_tabs();
    exp_tab[1] = 4'h8;
    wr_tab[1] = 1'b1; wr_tab[2] = 1'b1;
    bus.wt_valid = 1'b0;
    offer_cfg(16'd5, 16'd5, 16'd1, 16'd1, 16'd1, 32'd2, 32'd0);
    run_layer("abort", 3);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_strb", {bus.config_wren, bus.weight_wren, bus.pixel_datain_valid, bus.done},
             4'h0);
    check_eq("abort_rdy", {bus.cfg_ready, bus.wt_ready, bus.pix_ready, bus.busy}, 4'b1000);
    check_eq("abort_data", bus.datain, '0);
    check_eq("abort_err", bus.credit_err, 1'b0);
    check_eq("abort_credit", dut.credit_q, DEPTH);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
